// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with hex decode, per-digit DP/blank/blink,
// PWM brightness, anti-ghost dead time and a shadow buffer committed only at frame wrap.
module sevseg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned DEAD_CYCLES    = 64,
    parameter int unsigned PWM_BITS       = 4,
    parameter int unsigned BLINK_DIV_LOG2 = 25
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic                    pending,
    output logic                    frame_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_DEAD = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]               slot_q, slot_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [PWM_BITS-1:0]             pwm_q;
    logic [BLINK_DIV_LOG2-1:0]       blink_cnt_q;
    logic                            slot_end, wrap, lit;

    logic [NUM_DIGITS-1:0][3:0]      sh_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0]           sh_dp_q, sh_blank_q, sh_blink_q;
    logic [NUM_DIGITS-1:0]           act_dp_q, act_blank_q, act_blink_q;
    logic                            pending_q;

    logic [NUM_DIGITS-1:0]           an_q, an_d;
    logic [6:0]                      seg_q, seg_d;
    logic                            dp_q, dp_d;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end = (slot_q == SLOT_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
        slot_d   = slot_end ? '0 : slot_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        lit = (slot_q >= SLOT_DEAD) && (pwm_q <= brightness) && !act_blank_q[idx_q]
              && !(act_blink_q[idx_q] && blink_cnt_q[BLINK_DIV_LOG2-1]);
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(act_digits_q[idx_q]);
            dp_d        = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            blink_cnt_q <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_q + 1'b1;
            blink_cnt_q <= blink_cnt_q + 1'b1;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    // Commit happens only at frame wrap so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '1;
            sh_blink_q   <= '0;
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_blink_q  <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (wrap) begin
                act_digits_q <= sh_digits_q;
                act_dp_q     <= sh_dp_q;
                act_blank_q  <= sh_blank_q;
                act_blink_q  <= sh_blink_q;
                pending_q    <= 1'b0;
            end
            if (load) begin
                sh_digits_q <= digits_in;
                sh_dp_q     <= dp_in;
                sh_blank_q  <= blank_in;
                sh_blink_q  <= blink_in;
                pending_q   <= 1'b1;
            end
        end
    end

    assign frame_done = wrap;
    assign pending    = pending_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;

endmodule
